// File: rtl/sp_filter_pkg.sv
// rtl/sp_filter_pkg.sv - shared state encoding and default widths for the line filter
package sp_filter_pkg;

  localparam int PIXEL_W_DEF = 8;
  localparam int ADDR_W_DEF  = 16;
  localparam int LEN_W_DEF   = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_FIRST,
    ST_RD_NEXT,
    ST_PROCESS,
    ST_WRITE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/median3.sv
// rtl/median3.sv - combinational unsigned median of three via a min/max network
module median3
  import sp_filter_pkg::*;
#(
  parameter int PIXEL_W = PIXEL_W_DEF
) (
  input  logic [PIXEL_W-1:0] a,
  input  logic [PIXEL_W-1:0] b,
  input  logic [PIXEL_W-1:0] c,
  output logic [PIXEL_W-1:0] med
);

  logic [PIXEL_W-1:0] lo_ab;
  logic [PIXEL_W-1:0] hi_ab;
  logic [PIXEL_W-1:0] lo_hc;

  // median = max(min(a,b), min(max(a,b),c)); ties fall out naturally
  assign lo_ab = (a < b) ? a : b;
  assign hi_ab = (a < b) ? b : a;
  assign lo_hc = (hi_ab < c) ? hi_ab : c;
  assign med   = (lo_ab > lo_hc) ? lo_ab : lo_hc;

endmodule

// File: rtl/sp_line_filter_ctrl.sv
// rtl/sp_line_filter_ctrl.sv - start/done sequencer running a 3-tap median filter over one line
module sp_line_filter_ctrl
  import sp_filter_pkg::*;
#(
  parameter int PIXEL_W = PIXEL_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int LEN_W   = LEN_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W-1:0]  src_base,
  input  logic [ADDR_W-1:0]  dst_base,
  input  logic [LEN_W-1:0]   len,
  output logic               busy,
  output logic               done,
  output logic               rd_req,
  output logic [ADDR_W-1:0]  rd_addr,
  input  logic               rd_valid,
  input  logic [PIXEL_W-1:0] rd_data,
  output logic               wr_req,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [PIXEL_W-1:0] wr_data,
  input  logic               wr_ack
);

  state_t             state;
  state_t             state_nxt;
  logic [ADDR_W-1:0]  src_q;
  logic [ADDR_W-1:0]  dst_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   idx;
  logic [LEN_W-1:0]   idx_inc;
  logic [PIXEL_W-1:0] prev_px;
  logic [PIXEL_W-1:0] cur_px;
  logic [PIXEL_W-1:0] next_px;
  logic [PIXEL_W-1:0] med;

  assign idx_inc = idx + LEN_W'(1);

  median3 #(.PIXEL_W(PIXEL_W)) u_median3 (
    .a   (prev_px),
    .b   (cur_px),
    .c   (next_px),
    .med (med)
  );

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    rd_req    = 1'b0;
    rd_addr   = '0;
    wr_req    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = (len == '0) ? ST_DONE : ST_RD_FIRST;
      end
      ST_RD_FIRST: begin
        busy    = 1'b1;
        rd_req  = 1'b1;
        rd_addr = src_q;
        if (rd_valid) state_nxt = (len_q == LEN_W'(1)) ? ST_PROCESS : ST_RD_NEXT;
      end
      ST_RD_NEXT: begin
        busy    = 1'b1;
        rd_req  = 1'b1;
        rd_addr = src_q + ADDR_W'(idx) + ADDR_W'(1);
        if (rd_valid) state_nxt = ST_PROCESS;
      end
      ST_PROCESS: begin
        busy      = 1'b1;
        state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        busy   = 1'b1;
        wr_req = 1'b1;
        if (wr_ack) begin
          if (idx_inc == len_q)
            state_nxt = ST_DONE;
          else if (idx_inc == len_q - LEN_W'(1))
            state_nxt = ST_PROCESS;
          else
            state_nxt = ST_RD_NEXT;
        end
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      idx     <= '0;
      prev_px <= '0;
      cur_px  <= '0;
      next_px <= '0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (start) begin
            src_q <= src_base;
            dst_q <= dst_base;
            len_q <= len;
            idx   <= '0;
          end
        end
        ST_RD_FIRST: begin
          // left edge replicates the first pixel into prev as well as cur
          if (rd_valid) begin
            prev_px <= rd_data;
            cur_px  <= rd_data;
            if (len_q == LEN_W'(1)) next_px <= rd_data;
          end
        end
        ST_RD_NEXT: begin
          if (rd_valid) next_px <= rd_data;
        end
        ST_PROCESS: begin
          wr_data <= med;
          wr_addr <= dst_q + ADDR_W'(idx);
        end
        ST_WRITE: begin
          // next_px is left alone so the last pixel sees a replicated right edge
          if (wr_ack) begin
            prev_px <= cur_px;
            cur_px  <= next_px;
            idx     <= idx_inc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sp_line_filter_ctrl.sv
// tb/tb_sp_line_filter_ctrl.sv - self-checking bench for sp_line_filter_ctrl
module tb_sp_line_filter_ctrl;

  localparam int PW = 8;
  localparam int AW = 16;
  localparam int LW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] src_base;
  logic [AW-1:0] dst_base;
  logic [LW-1:0] len;
  logic          busy;
  logic          done;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_valid;
  logic [PW-1:0] rd_data;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [PW-1:0] wr_data;
  logic          wr_ack;

  sp_line_filter_ctrl #(.PIXEL_W(PW), .ADDR_W(AW), .LEN_W(LW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .src_base (src_base),
    .dst_base (dst_base),
    .len      (len),
    .busy     (busy),
    .done     (done),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .wr_req   (wr_req),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_ack   (wr_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0]    src;
    logic [AW-1:0]    dst;
    logic [LW-1:0]    len;
    bit               rd_rand;
    int               wr_hold;
    logic [0:7][7:0]  pix;
    logic [0:7][7:0]  res;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [PW-1:0]    mem [0:65535];
  logic [AW-1:0]    exp_rd[$];
  logic [AW+PW-1:0] exp_wr[$];
  int rd_cnt, wr_cnt, done_cnt, done_cyc, overlap, req_seen, stable_err;
  bit rd_rand;
  int wr_hold;
  vec_t tbl [5];
  vec_t rst_vec, post_vec, wrap_vec;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // read responder with optional random latency
  initial begin
    bit            act;
    int            cnt;
    logic [AW-1:0] hold;
    logic [AW-1:0] e;
    act = 0; cnt = 0; hold = '0;
    rd_valid = 1'b0; rd_data = '0;
    forever begin
      @(negedge clk);
      rd_valid = 1'b0;
      rd_data  = 8'($urandom);
      if (!rd_req) act = 0;
      else begin
        if (!act) begin
          act  = 1;
          hold = rd_addr;
          cnt  = rd_rand ? $urandom_range(0, 4) : 0;
        end else if (rd_addr !== hold) stable_err++;
        if (cnt == 0) begin
          rd_valid = 1'b1;
          rd_data  = mem[rd_addr];
          act      = 0;
          rd_cnt++;
          check("rd_expected", exp_rd.size() > 0, 1);
          if (exp_rd.size() > 0) begin
            e = exp_rd.pop_front();
            check("rd_addr", rd_addr, e);
          end
        end else cnt--;
      end
    end
  end

  // write responder holding ack off for wr_hold cycles
  initial begin
    bit               act;
    int               cnt;
    logic [AW+PW-1:0] hold;
    logic [AW+PW-1:0] e;
    act = 0; cnt = 0; hold = '0;
    wr_ack = 1'b0;
    forever begin
      @(negedge clk);
      wr_ack = 1'b0;
      if (!wr_req) act = 0;
      else begin
        if (!act) begin
          act  = 1;
          hold = {wr_addr, wr_data};
          cnt  = wr_hold;
        end else if ({wr_addr, wr_data} !== hold) stable_err++;
        if (cnt == 0) begin
          wr_ack = 1'b1;
          act    = 0;
          wr_cnt++;
          check("wr_expected", exp_wr.size() > 0, 1);
          if (exp_wr.size() > 0) begin
            e = exp_wr.pop_front();
            check("wr_addr_data", {8'h0, wr_addr, wr_data}, {8'h0, e});
          end
        end else cnt--;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (rd_req && wr_req) overlap++;
      if (rd_req || wr_req) req_seen++;
    end
  end

  task automatic load_vec(input vec_t v);
    for (int k = 0; k < int'(v.len); k++) begin
      mem[v.src + 16'(k)] = v.pix[k];
      exp_rd.push_back(v.src + 16'(k));
      exp_wr.push_back({v.dst + 16'(k), v.res[k]});
    end
    rd_rand = v.rd_rand;
    wr_hold = v.wr_hold;
    rd_cnt = 0; wr_cnt = 0; done_cnt = 0; done_cyc = 0;
    overlap = 0; req_seen = 0; stable_err = 0;
  endtask

  task automatic run_vec(input vec_t v, input int restart_at);
    int start_cyc;
    load_vec(v);
    @(negedge clk);
    start = 1'b1; src_base = v.src; dst_base = v.dst; len = v.len;
    start_cyc = cyc;
    for (int c = 0; c < 3000 && done_cnt == 0; c++) begin
      @(negedge clk);
      start = (restart_at != 0 && c == restart_at);
      if (start) begin src_base = 16'h0100; len = 10'd2; end
      if (c == 0 && v.len != 0) check("busy_after_start", busy, 1);
    end
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("done_count", done_cnt, 1);
    check("rd_count", rd_cnt, 32'(v.len));
    check("wr_count", wr_cnt, 32'(v.len));
    check("busy_idle", busy, 0);
    check("rd_q_empty", exp_rd.size(), 0);
    check("wr_q_empty", exp_wr.size(), 0);
    check("req_overlap", overlap, 0);
    check("addr_data_stable", stable_err, 0);
    if (v.len == 0) check("no_req_len0", req_seen, 0);
    if (v.len == 0) check("done_cycle_len0", done_cyc - start_cyc + 1, 2);
    if (v.len == 1) check("done_cycle_len1", done_cyc - start_cyc + 1, 5);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{16'h1000, 16'h2000, 10'd5, 1'b0, 0,
               {8'd10, 8'd255, 8'd12, 8'd0, 8'd14, 8'd0, 8'd0, 8'd0},
               {8'd10, 8'd12, 8'd12, 8'd12, 8'd14, 8'd0, 8'd0, 8'd0}};
    tbl[1] = '{16'h1100, 16'h2100, 10'd1, 1'b0, 0,
               {8'd200, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0},
               {8'd200, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}};
    tbl[2] = '{16'h1200, 16'h2200, 10'd0, 1'b0, 0, '0, '0};
    tbl[3] = '{16'h1300, 16'h2300, 10'd5, 1'b1, 3,
               {8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0},
               {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}};
    tbl[4] = '{16'h1400, 16'h2400, 10'd3, 1'b1, 1,
               {8'd50, 8'd40, 8'd60, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0},
               {8'd50, 8'd50, 8'd60, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}};
    rst_vec  = '{16'h1500, 16'h2500, 10'd5, 1'b0, 3,
                 {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0, 8'd0, 8'd0},
                 {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0, 8'd0, 8'd0}};
    post_vec = '{16'h1600, 16'h2600, 10'd3, 1'b0, 0,
                 {8'd30, 8'd10, 8'd20, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0},
                 {8'd30, 8'd20, 8'd20, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}};
    wrap_vec = '{16'hFFFE, 16'h3000, 10'd4, 1'b1, 0,
                 {8'd5, 8'd9, 8'd7, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0},
                 {8'd5, 8'd7, 8'd7, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0}};

    rst = 1'b1; start = 1'b0; src_base = '0; dst_base = '0; len = '0;
    rd_rand = 0; wr_hold = 0;
    #1 rst = 1'b0;
    #3;
    check("reset_ctrl", {busy, done, rd_req, wr_req}, 0);
    check("reset_rd_addr", rd_addr, 0);
    check("reset_wr_addr", wr_addr, 0);
    check("reset_wr_data", wr_data, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("no_req_after_release", {rd_req, wr_req, busy}, 0);

    for (int t = 0; t < 5; t++) run_vec(tbl[t], 0);

    // abandon a line while waiting on the write of pixel 2
    load_vec(rst_vec);
    @(negedge clk);
    start = 1'b1; src_base = rst_vec.src; dst_base = rst_vec.dst; len = rst_vec.len;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 500 && !(wr_req && wr_addr == 16'h2502); c++) @(negedge clk);
    check("reached_write2", wr_req && wr_addr == 16'h2502, 1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_ctrl", {busy, done, rd_req, wr_req}, 0);
    check("async_rst_rd_addr", rd_addr, 0);
    check("async_rst_wr_addr", wr_addr, 0);
    check("async_rst_wr_data", wr_data, 0);
    exp_rd.delete();
    exp_wr.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("idle_after_abort", {rd_req, wr_req, busy, done}, 0);
    run_vec(post_vec, 0);

    // address wrap with a second start pulsed while busy
    run_vec(wrap_vec, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
